// File: rtl/mux_sel_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_sel_seq_pkg                                                            |
// | Shared FSM state type and control-register bit layout for mux_sel_seq.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mux_sel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREAK  = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MAKE   = 3'd3,
    ST_POTREQ = 3'd4
  } state_t;

  localparam int c_pot_lsb       = 0;
  localparam int c_pot_w         = 14;
  localparam int c_stat_pot_busy = 14;
  localparam int c_stat_seq_busy = 15;
  localparam int c_grp_lsb       = 16;
  localparam int c_grp_w         = 8;
  localparam int c_fld_en        = 7;
  localparam int c_fld_cs_lsb    = 5;
  localparam int c_fld_cs_w      = 2;
  localparam int c_en_w          = 4;

  function automatic int grp_lsb(input int g);
    return c_grp_lsb + g * c_grp_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_seq_grp_drv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_grp_drv                                                                |
// | Registered address / one-hot enable driver for one mux group.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_grp_drv
  import mux_sel_seq_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  state_t                i_state,
  input  logic                  i_kill,
  input  logic                  i_fld_en,
  input  logic [c_fld_cs_w-1:0] i_fld_cs,
  input  logic [ADDR_W-1:0]     i_fld_addr,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [c_en_w-1:0]     o_en
);

  logic [ADDR_W-1:0] r_addr;
  logic [c_en_w-1:0] r_en;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_addr <= '0;
      r_en   <= '0;
    end else begin
      case (i_state)
        ST_ADDR: r_addr <= i_fld_addr;
        ST_MAKE: if (!i_fld_en) r_addr <= '0;
        default: ;
      endcase
      // A fresh write drops the enable at once, even over a pending make.
      if (i_kill) begin
        r_en <= '0;
      end else begin
        case (i_state)
          ST_MAKE:           r_en <= i_fld_en ? (c_en_w'(1) << i_fld_cs) : '0;
          ST_BREAK, ST_ADDR: r_en <= '0;
          default: ;
        endcase
      end
    end
  end

  assign o_addr = r_addr;
  assign o_en   = r_en;

endmodule
`default_nettype wire

// File: rtl/mux_sel_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_sel_seq                                                                |
// | Break-before-make mux select sequencer with potentiometer SPI hand-off.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_sel_seq
  import mux_sel_seq_pkg::*;
#(
  parameter int N_GRP      = 2,
  parameter int ADDR_W     = 3,
  parameter int BREAK_CYC  = 2,
  parameter int SETTLE_CYC = 4,
  parameter int POT_CS     = 2
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      valid_pci,
  input  logic                      sel_reg_sel,
  input  logic                      rd_wr,
  input  logic [31:0]               ad_to_tuvv,
  output logic [31:0]               ad_from_tuvv,
  input  logic                      pot_busy,
  input  logic                      send_ok_strobe,
  output logic                      send_data_spi,
  output logic [13:0]               dat_spi_out,
  output logic [N_GRP*ADDR_W-1:0]   mux_addr,
  output logic [N_GRP*c_en_w-1:0]   mux_en,
  output logic                      seq_busy
);

  localparam int c_cnt_max = (BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0]    c_break_ld  = c_cnt_w'(BREAK_CYC - 1);
  localparam logic [c_cnt_w-1:0]    c_settle_ld = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_fld_cs_w-1:0] c_pot_cs    = c_fld_cs_w'(POT_CS);

  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]        r_shadow, r_active, w_rd_word;
  logic               r_send;
  logic               w_wr_acc, w_rd_acc, w_pot_sel;
  logic               w_seq_busy, w_load_active, w_spi_set;

  assign w_wr_acc  = sel_reg_sel & valid_pci & rd_wr;
  assign w_rd_acc  = sel_reg_sel & ~rd_wr;
  assign w_pot_sel = r_active[c_grp_lsb + c_fld_en] &&
                     (r_active[c_grp_lsb + c_fld_cs_lsb +: c_fld_cs_w] == c_pot_cs);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_wr_acc) begin
      w_state_nxt = ST_BREAK;
      w_cnt_nxt   = c_break_ld;
    end else begin
      case (r_state)
        ST_BREAK:
          if (r_cnt == '0) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = c_settle_ld;
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_one;
          end
        ST_ADDR:
          if (r_cnt == '0) begin
            w_state_nxt = ST_MAKE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_one;
          end
        ST_MAKE: begin
          w_state_nxt = w_pot_sel ? ST_POTREQ : ST_IDLE;
          w_cnt_nxt   = '0;
        end
        ST_POTREQ:
          if (!pot_busy) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_seq_busy    = (r_state != ST_IDLE);
    w_load_active = (r_state == ST_BREAK) && (r_cnt == '0);
    w_spi_set     = (r_state == ST_POTREQ) && !pot_busy;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_shadow <= '0;
      r_active <= '0;
      r_send   <= 1'b0;
    end else begin
      if (w_wr_acc)      r_shadow <= ad_to_tuvv;
      if (w_load_active) r_active <= r_shadow;
      // Clear beats set so a done strobe can never be lost to a same-cycle request.
      if (w_wr_acc || send_ok_strobe) r_send <= 1'b0;
      else if (w_spi_set)             r_send <= 1'b1;
    end
  end

  always_comb begin
    w_rd_word                  = r_active;
    w_rd_word[c_stat_seq_busy] = w_seq_busy;
    w_rd_word[c_stat_pot_busy] = pot_busy;
  end

  assign ad_from_tuvv  = w_rd_acc ? w_rd_word : '0;
  assign dat_spi_out   = w_pot_sel ? r_active[c_pot_lsb +: c_pot_w] : '0;
  assign send_data_spi = r_send;
  assign seq_busy      = w_seq_busy;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    localparam int c_lsb = grp_lsb(g);
    mux_grp_drv #(
      .ADDR_W(ADDR_W)
    ) u_drv (
      .clk       (clk),
      .rst_      (rst_),
      .i_state   (r_state),
      .i_kill    (w_wr_acc),
      .i_fld_en  (r_active[c_lsb + c_fld_en]),
      .i_fld_cs  (r_active[c_lsb + c_fld_cs_lsb +: c_fld_cs_w]),
      .i_fld_addr(r_active[c_lsb +: ADDR_W]),
      .o_addr    (mux_addr[g*ADDR_W +: ADDR_W]),
      .o_en      (mux_en[g*c_en_w +: c_en_w])
    );
  end

endmodule
`default_nettype wire
